sprite_fetch_arbiter: RTL

- Shares one sprite image ROM and palette chain between NUM_SPRITES fruit sprites, each sized SPRITE_W x SPRITE_H.
- Per VGA pixel: finds which enabled sprite covers (x,y), computes that sprite's ROM address and id, and tracks the request through the ROM latency.
- Returns the 12-bit colour with a hit/transparency qualifier.
- Sits between the VGA timing generator and the shared image/palette RAM pair; the game logic supplies positions.

---
 rtl/sprite_fetch_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sprite_fetch_arbiter.sv
// Shared sprite ROM fetch arbiter: per-pixel hit test across NUM_SPRITES, ROM address/id issue, colour return.
// Optional collision statistics are enabled by defining SPRITE_COLLIDE_EN.

module sprite_fetch_lane #(
  parameter int SPRITE_W = 50,
  parameter int SPRITE_H = 50,
  parameter int ADDR_W   = 13
) (
  input  logic              en,
  input  logic              pix_valid,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  input  logic [9:0]        sx,
  input  logic [8:0]        sy,
  output logic              hit,
  output logic [ADDR_W-1:0] addr
);
  logic [10:0] x_end;
  logic [9:0]  y_end;
  logic [9:0]  dx;
  logic [8:0]  dy;

  // One extra bit so a sprite hanging off the right/bottom never wraps to 0
  assign x_end = {1'b0, sx} + 11'(SPRITE_W);
  assign y_end = {1'b0, sy} + 10'(SPRITE_H);
  assign hit   = en && pix_valid && (x >= sx) && ({1'b0, x} < x_end) &&
                 (y >= sy) && ({1'b0, y} < y_end);
  assign dx    = x - sx;
  assign dy    = y - sy;
  assign addr  = ADDR_W'(int'(dx) + SPRITE_W * int'(dy));
endmodule

module sprite_fetch_arbiter #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 50,
  parameter int SPRITE_H    = 50,
  parameter int ADDR_W      = 13,
  parameter int ID_W        = 2,
  parameter int COLOR_W     = 12,
  parameter int RAM_LATENCY = 2,
  parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(12'h0F0)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  input  logic [9:0]               x,
  input  logic [8:0]               y,
  input  logic [NUM_SPRITES-1:0]   sprite_en,
  input  logic [10*NUM_SPRITES-1:0] sprite_x,
  input  logic [9*NUM_SPRITES-1:0] sprite_y,
  output logic [ADDR_W-1:0]        rom_addr,
  output logic [ID_W-1:0]          rom_id,
  input  logic [COLOR_W-1:0]       rom_color,
  output logic                     out_valid,
  output logic                     out_hit,
  output logic [COLOR_W-1:0]       out_color
`ifdef SPRITE_COLLIDE_EN
  ,
  output logic                     collide_flag,
  output logic [15:0]              collide_count
`endif
);
  logic [NUM_SPRITES-1:0]             sh_en;
  logic [NUM_SPRITES-1:0][9:0]        sh_x;
  logic [NUM_SPRITES-1:0][8:0]        sh_y;
  logic [NUM_SPRITES-1:0]             hit;
  logic [NUM_SPRITES-1:0][ADDR_W-1:0] lane_addr;
  logic                               any_hit;
  logic [ADDR_W-1:0]                  win_addr;
  logic [ID_W-1:0]                    win_id;
  logic [RAM_LATENCY:0]               vld_pipe;
  logic [RAM_LATENCY:0]               hit_pipe;
  logic                               opaque;

  // Positions change only at frame boundaries so a sprite never tears mid-frame
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sh_en <= '0;
      sh_x  <= '0;
      sh_y  <= '0;
    end else if (frame_start) begin
      sh_en <= sprite_en;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        sh_x[i] <= sprite_x[10*i +: 10];
        sh_y[i] <= sprite_y[9*i +: 9];
      end
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_lane
    sprite_fetch_lane #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .ADDR_W   (ADDR_W)
    ) u_lane (
      .en        (sh_en[g]),
      .pix_valid (pix_valid),
      .x         (x),
      .y         (y),
      .sx        (sh_x[g]),
      .sy        (sh_y[g]),
      .hit       (hit[g]),
      .addr      (lane_addr[g])
    );
  end

  // Scan high to low so the lowest index is the last writer and wins
  always_comb begin
    any_hit  = 1'b0;
    win_addr = '0;
    win_id   = '0;
    for (int i = NUM_SPRITES-1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit  = 1'b1;
        win_addr = lane_addr[i];
        win_id   = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rom_addr <= '0;
      rom_id   <= '0;
      vld_pipe <= '0;
      hit_pipe <= '0;
    end else begin
      rom_addr    <= win_addr;
      rom_id      <= win_id;
      vld_pipe[0] <= pix_valid;
      hit_pipe[0] <= any_hit;
      for (int i = 1; i <= RAM_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        hit_pipe[i] <= hit_pipe[i-1];
      end
    end
  end

  assign opaque = hit_pipe[RAM_LATENCY] && (rom_color != TRANSPARENT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_color <= '0;
    end else begin
      out_valid <= vld_pipe[RAM_LATENCY];
      out_hit   <= opaque;
      out_color <= opaque ? rom_color : '0;
    end
  end

`ifdef SPRITE_COLLIDE_EN
  logic        multi;
  logic        acc_flag;
  logic [15:0] acc_count;
  logic        flag_next;
  logic [15:0] count_next;

  // Two or more bits set <=> clearing the lowest set bit leaves something
  assign multi      = |(hit & (hit - 1'b1));
  assign flag_next  = acc_flag | multi;
  assign count_next = (multi && acc_count != 16'hFFFF) ? acc_count + 16'd1 : acc_count;

  // The frame_start pixel still belongs to the frame being reported
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_flag      <= 1'b0;
      acc_count     <= '0;
      collide_flag  <= 1'b0;
      collide_count <= '0;
    end else if (frame_start) begin
      collide_flag  <= flag_next;
      collide_count <= count_next;
      acc_flag      <= 1'b0;
      acc_count     <= '0;
    end else begin
      acc_flag  <= flag_next;
      acc_count <= count_next;
    end
  end
`else
  // No collision tracking; the priority path above is the whole design.
`endif
endmodule
